board_loader: RTL and testbench
===============================

BOARD_LOADER -- requirements
Module: board_loader

Interface
REQ-001 SHALL have parameter PIECE_WIDTH, default 4, bits per square code.
REQ-002 SHALL have parameter ROW_WIDTH, default 32, bits per rank (8 x PIECE_WIDTH).
REQ-003 SHALL have parameter BOARD_WIDTH, default 256, bits per board (8 x ROW_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_piece  input  PIECE_WIDTH  beat payload: square code, or side-to-move in bit 0.
REQ-007 SHALL have port in_sof  input  1  marks first beat of a frame.
REQ-008 SHALL have port in_valid  input  1  beat present.
REQ-009 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port board  output  BOARD_WIDTH  last complete board; square n at bits [n*PIECE_WIDTH +: PIECE_WIDTH].
REQ-011 SHALL have port board_valid  output  1  one-cycle pulse when board is updated; drives display_board display.
REQ-012 SHALL have port white_to_move  output  1  side to move of the last complete frame.
REQ-013 SHALL have port frame_error  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 Frame SHALL be 65 accepted beats: 64 squares in index order 0..63, then one side beat.
REQ-015 Squares SHALL be assembled in a shadow register; board and white_to_move SHALL change only on frame completion.
REQ-016 FSM SHALL have states IDLE, LOAD, SIDE, PRESENT.
REQ-017 IDLE: accepted beat with in_sof=1 SHALL write square 0, set count=1 and go to LOAD; beats with in_sof=0 SHALL be accepted and dropped.
REQ-018 LOAD: accepted beat with in_sof=0 SHALL write square[count] and increment count; after square 63 the FSM SHALL go to SIDE.
REQ-019 SIDE: accepted beat with in_sof=0 SHALL latch in_piece[0] as the pending side to move and go to PRESENT.
REQ-020 PRESENT (one cycle): board SHALL take the shadow value, white_to_move SHALL take the pending side, board_valid SHALL be 1, in_ready SHALL be 0; then IDLE.
REQ-021 Latency: board_valid SHALL assert exactly one cycle after the side beat is accepted.
REQ-022 in_sof=1 accepted in LOAD or SIDE SHALL pulse frame_error the next cycle, write square 0, set count=1 and stay in or return to LOAD; board SHALL be unchanged.
REQ-023 in_ready SHALL be 1 in IDLE, LOAD and SIDE, and 0 in PRESENT and while reset is low.
REQ-024 Idle cycles (in_valid=0) SHALL not advance count or state.
REQ-025 Count SHALL be 6 bits and never wrap; the transition to SIDE replaces the increment past 63.

Reset
REQ-026 While reset=0, state SHALL be IDLE, count 0, board all zeros, white_to_move 0, board_valid 0, frame_error 0, in_ready 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; the shadow register need not be cleared.

Structure
REQ-028 Shared package vchess_pkg SHALL hold board geometry constants (squares=64, ranks=8), piece-code constants and the loader state enum.
REQ-029 The block SHALL be a single module with no sub-module; a parent SHALL connect board/board_valid directly to display_board.

Verification
REQ-030 Frame with square n = n mod 16 and side=1, no gaps -> board_valid high for one cycle, exactly one cycle after beat 65; board[n*4+:4]=n mod 16; white_to_move=1.
REQ-031 Same frame with in_valid randomly low 50% of cycles -> identical board; one board_valid pulse; no change before completion.
REQ-032 Complete frame A, then frame B with in_sof reasserted at beat 30 -> frame_error pulse; board still equals A; the restarted 65-beat B then publishes B.
REQ-033 Reset low for 2 cycles at beat 40 -> all outputs at reset values; next full frame publishes correctly.
REQ-034 Ten beats with in_sof=0 in IDLE, then a valid frame -> stray beats dropped; correct board published.
REQ-035 Two back-to-back frames with in_valid held high -> in_ready low for exactly one cycle between frames; two board_valid pulses 66 cycles apart.

Source files
------------

// File: rtl/vchess_pkg.sv
// Shared chess definitions: board geometry, piece codes and the loader FSM state type.
package vchess_pkg;

  localparam int SQUARES = 64;
  localparam int RANKS   = 8;
  localparam int FILES   = 8;
  localparam int SQ_IDX_W = 6;

  // Bit 3 of a piece code selects black; codes 7, 8 and 15 are unused.
  localparam logic [3:0] PC_EMPTY    = 4'd0;
  localparam logic [3:0] PC_W_PAWN   = 4'd1;
  localparam logic [3:0] PC_W_KNIGHT = 4'd2;
  localparam logic [3:0] PC_W_BISHOP = 4'd3;
  localparam logic [3:0] PC_W_ROOK   = 4'd4;
  localparam logic [3:0] PC_W_QUEEN  = 4'd5;
  localparam logic [3:0] PC_W_KING   = 4'd6;
  localparam logic [3:0] PC_B_PAWN   = 4'd9;
  localparam logic [3:0] PC_B_KNIGHT = 4'd10;
  localparam logic [3:0] PC_B_BISHOP = 4'd11;
  localparam logic [3:0] PC_B_ROOK   = 4'd12;
  localparam logic [3:0] PC_B_QUEEN  = 4'd13;
  localparam logic [3:0] PC_B_KING   = 4'd14;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_LOAD    = 2'd1,
    LD_SIDE    = 2'd2,
    LD_PRESENT = 2'd3
  } loader_state_t;

  function automatic logic pc_is_black(input logic [3:0] code);
    return code[3];
  endfunction

endpackage

// File: rtl/board_loader.sv
// Assembles 64 square beats plus a side beat into a shadow board, publishing it one cycle after the side beat.
// Backpressure: in_ready drops only for the single publish cycle and while reset is low; a new sof restarts the frame.
module board_loader
  import vchess_pkg::*;
#(
  parameter int PIECE_WIDTH = 4,
  parameter int ROW_WIDTH   = 32,
  parameter int BOARD_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIECE_WIDTH-1:0] in_piece,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BOARD_WIDTH-1:0] board,
  output logic                   board_valid,
  output logic                   white_to_move,
  output logic                   frame_error
);

  localparam logic [SQ_IDX_W-1:0] LAST_SQ = SQ_IDX_W'(SQUARES - 1);

  loader_state_t r_state;
  loader_state_t w_state_nxt;
  logic [SQ_IDX_W-1:0] r_count;
  logic [SQ_IDX_W-1:0] w_count_nxt;
  logic [SQ_IDX_W-1:0] w_sq_idx;
  logic w_sq_we;
  logic w_publish;
  logic w_abort;
  logic w_accept;

  logic [RANKS-1:0][FILES-1:0][PIECE_WIDTH-1:0] r_shadow;
  logic [BOARD_WIDTH-1:0] r_board;
  logic r_white_to_move;
  logic r_frame_error;

  assign in_ready      = reset && (r_state != LD_PRESENT);
  assign w_accept      = in_valid && in_ready;
  assign board         = r_board;
  assign board_valid   = (r_state == LD_PRESENT);
  assign white_to_move = r_white_to_move;
  assign frame_error   = r_frame_error;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_sq_we     = 1'b0;
    w_sq_idx    = r_count;
    w_publish   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      LD_IDLE: begin
        if (w_accept && in_sof) begin
          w_sq_we     = 1'b1;
          w_sq_idx    = '0;
          w_count_nxt = SQ_IDX_W'(1);
          w_state_nxt = LD_LOAD;
        end
      end
      LD_LOAD, LD_SIDE: begin
        if (w_accept) begin
          if (in_sof) begin
            // Restart: the new beat becomes square 0 of a fresh frame.
            w_abort     = 1'b1;
            w_sq_we     = 1'b1;
            w_sq_idx    = '0;
            w_count_nxt = SQ_IDX_W'(1);
            w_state_nxt = LD_LOAD;
          end else if (r_state == LD_LOAD) begin
            w_sq_we = 1'b1;
            if (r_count == LAST_SQ) begin
              w_state_nxt = LD_SIDE;
            end else begin
              w_count_nxt = r_count + SQ_IDX_W'(1);
            end
          end else begin
            w_publish   = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = LD_PRESENT;
          end
        end
      end
      LD_PRESENT: begin
        w_state_nxt = LD_IDLE;
      end
      default: begin
        w_state_nxt = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= LD_IDLE;
      r_count         <= '0;
      r_board         <= '0;
      r_white_to_move <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_frame_error <= w_abort;
      // Board and side load together so both are valid during the board_valid cycle.
      if (w_publish) begin
        for (int r = 0; r < RANKS; r++) begin
          r_board[r*ROW_WIDTH +: ROW_WIDTH] <= r_shadow[r];
        end
        r_white_to_move <= in_piece[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_sq_we) begin
      r_shadow[w_sq_idx[5:3]][w_sq_idx[2:0]] <= in_piece;
    end
  end

endmodule

// File: tb/tb_board_loader.sv
// Scoreboard bench for board_loader: expected boards are queued as frames are driven and checked on board_valid.
module tb_board_loader;
  import vchess_pkg::*;

  localparam int PW = 4;
  localparam int RW = 32;
  localparam int BW = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] in_piece = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] board;
  logic          board_valid;
  logic          white_to_move;
  logic          frame_error;

  board_loader #(.PIECE_WIDTH(PW), .ROW_WIDTH(RW), .BOARD_WIDTH(BW)) dut (
    .clk(clk),
    .reset(reset),
    .in_piece(in_piece),
    .in_sof(in_sof),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .board(board),
    .board_valid(board_valid),
    .white_to_move(white_to_move),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0] brd;
    logic          wtm;
  } exp_t;

  exp_t sb_q[$];
  int   pulse_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   n_pulses = 0;
  int   n_ferr = 0;
  int   n_ready_low = 0;
  int   cyc = 0;
  logic [BW-1:0] prev_board = '0;
  logic          prev_bv = 1'b0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] sq_code(input int kind, input int n);
    int v;
    case (kind)
      0:       v = n % 16;
      1:       v = (n * 7 + 3) % 16;
      2:       v = 15 - (n % 16);
      3:       v = (n * 5 + 1) % 16;
      default: v = (n / 4) % 16;
    endcase
    return PW'(v);
  endfunction

  function automatic logic [BW-1:0] mk_board(input int kind);
    logic [BW-1:0] b;
    b = '0;
    for (int n = 0; n < 64; n++) b[n*PW +: PW] = sq_code(kind, n);
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: pops the scoreboard on every publish and watches for spurious board changes.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (board_valid) begin
        n_pulses++;
        pulse_cyc.push_back(cyc);
        if (prev_bv) check("bv_one_cycle", BW'(1), BW'(0));
        if (sb_q.size() == 0) begin
          check("unexpected_board_valid", BW'(1), BW'(0));
        end else begin
          e = sb_q.pop_front();
          check("board", board, e.brd);
          check("white_to_move", BW'(white_to_move), BW'(e.wtm));
        end
      end else if (board !== prev_board) begin
        check("board_stable", board, prev_board);
      end
      if (frame_error) n_ferr++;
      if (in_valid && !in_ready) n_ready_low++;
    end
    prev_board = board;
    prev_bv    = board_valid;
  end

  // Tasks start and end at posedge+1.
  task automatic beat(input logic [PW-1:0] p, input logic sof, input int gap_pct);
    int guard;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_piece = p;
    in_sof   = sof;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("ready_timeout", BW'(0), BW'(1));
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_squares(input int kind, input int first, input int last, input int gap_pct);
    for (int n = first; n <= last; n++) beat(sq_code(kind, n), n == 0, gap_pct);
  endtask

  task automatic side_beat(input logic side, input int gap_pct);
    logic [PW-1:0] p;
    p = PW'($urandom);
    p[0] = side;
    beat(p, 1'b0, gap_pct);
    check("bv_latency", BW'(board_valid), BW'(1));
  endtask

  task automatic push_exp(input int kind, input logic side);
    exp_t e;
    e.brd = mk_board(kind);
    e.wtm = side;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic send_frame(input int kind, input logic side, input int gap_pct);
    push_exp(kind, side);
    send_squares(kind, 0, 63, gap_pct);
    side_beat(side, gap_pct);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_board"}, board, '0);
    check({tag, "_bv"}, BW'(board_valid), BW'(0));
    check({tag, "_wtm"}, BW'(white_to_move), BW'(0));
    check({tag, "_ferr"}, BW'(frame_error), BW'(0));
    check({tag, "_ready"}, BW'(in_ready), BW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ferr0;
    int d;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    #1;
    check("ready_after_reset", BW'(in_ready), BW'(1));
    idle(2);

    // Basic frame, no gaps.
    send_frame(0, 1'b1, 0);
    idle(3);

    // Same frame with random 50% gaps.
    send_frame(0, 1'b1, 50);
    idle(3);

    // Frame A, then B aborted by an sof at beat 30 and restarted.
    send_frame(1, 1'b0, 0);
    idle(2);
    ferr0 = n_ferr;
    send_squares(2, 0, 29, 0);
    push_exp(2, 1'b1);
    beat(sq_code(2, 0), 1'b1, 0);
    check("ferr_pulse_load", BW'(frame_error), BW'(1));
    check("board_held_a", board, mk_board(1));
    send_squares(2, 1, 63, 0);
    side_beat(1'b1, 0);
    check("ferr_count_load", BW'(n_ferr - ferr0), BW'(1));
    idle(2);

    // Abort arriving in place of the side beat.
    ferr0 = n_ferr;
    send_squares(3, 0, 63, 0);
    push_exp(4, 1'b0);
    beat(sq_code(4, 0), 1'b1, 0);
    check("ferr_pulse_side", BW'(frame_error), BW'(1));
    check("board_held_b", board, mk_board(2));
    send_squares(4, 1, 63, 0);
    side_beat(1'b0, 0);
    check("ferr_count_side", BW'(n_ferr - ferr0), BW'(1));
    idle(2);

    // Reset in the middle of a frame.
    send_squares(3, 0, 39, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midreset1");
    @(posedge clk); #1;
    check_reset_outputs("midreset2");
    reset = 1'b1;
    idle(2);
    send_frame(3, 1'b1, 25);
    idle(2);

    // Stray beats without sof are dropped.
    for (int i = 0; i < 10; i++) beat(PW'($urandom), 1'b0, 0);
    idle(1);
    send_frame(1, 1'b1, 0);
    idle(3);

    // Back-to-back frames with in_valid held high.
    n_ready_low = 0;
    pulse_cyc.delete();
    send_frame(0, 1'b0, 0);
    send_frame(2, 1'b1, 0);
    idle(3);
    check("b2b_pulses", BW'(pulse_cyc.size()), BW'(2));
    d = (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1;
    check("b2b_spacing", BW'(d), BW'(66));
    check("b2b_ready_low", BW'(n_ready_low), BW'(1));

    idle(3);
    check("sb_drained", BW'(sb_q.size()), BW'(0));
    check("pulse_total", BW'(n_pulses), BW'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
